mul_add_param: RTL

//  Parametrised sequential multiplier using repeated addition: P = A*B built as A added B times.

---
 rtl/mul_add_pkg.sv | 12 +
 rtl/mul_add_param_ctrl.sv | 67 ++++++
 rtl/mul_add_param.sv | 94 +++++++++
 3 files changed

// File: rtl/mul_add_pkg.sv
// Shared state encoding for the repeated-addition multiplier.
package mul_add_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_add_param_ctrl.sv
// Control FSM for mul_add_param: sequences capture, accumulation and the done pulse.
module mul_add_param_ctrl
    import mul_add_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic eqz,
    output logic lda,
    output logic ldb,
    output logic ldp,
    output logic clrp,
    output logic decb,
    output logic busy,
    output logic done
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (eqz) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Loads happen on the accepting edge in IDLE; adds only while the counter is non-zero.
    always_comb begin
        lda  = 1'b0;
        ldb  = 1'b0;
        ldp  = 1'b0;
        clrp = 1'b0;
        decb = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                lda  = start;
                ldb  = start;
                clrp = start;
            end
            ACC: begin
                busy = 1'b1;
                ldp  = !eqz;
                decb = !eqz;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_add_param.sv
// Sequential multiplier that forms A*B by adding A to the product B times.
// Optional MUL_ADD_SWAP_EN loads the smaller operand as the iteration count.
module mul_add_param
    import mul_add_pkg::*;
#(
    parameter int W     = 16,
    parameter int OUT_W = 2 * W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] product,
    output logic             ovf
);

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W:0]   sum;
    logic             lda;
    logic             ldb;
    logic             ldp;
    logic             clrp;
    logic             decb;
    logic             eqz;

`ifdef MUL_ADD_SWAP_EN
    // Fewer iterations when the smaller value drives the counter; ties keep a_in as addend.
    always_comb begin
        if (a_in < b_in) begin
            a_sel = b_in;
            b_sel = a_in;
        end else begin
            a_sel = a_in;
            b_sel = b_in;
        end
    end
`else
    assign a_sel = a_in;
    assign b_sel = b_in;
`endif

    assign eqz   = (b_reg == '0);
    assign a_ext = OUT_W'(a_reg);
    assign sum   = {1'b0, product} + {1'b0, a_ext};

    mul_add_param_ctrl u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .eqz   (eqz),
        .lda   (lda),
        .ldb   (ldb),
        .ldp   (ldp),
        .clrp  (clrp),
        .decb  (decb),
        .busy  (busy),
        .done  (done)
    );

    // ovf is sticky across the whole operation and cleared only on a new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            if (lda) begin
                a_reg <= a_sel;
            end
            if (ldb) begin
                b_reg <= b_sel;
            end else if (decb) begin
                b_reg <= b_reg - W'(1);
            end
            if (clrp) begin
                product <= '0;
                ovf     <= 1'b0;
            end else if (ldp) begin
                product <= sum[OUT_W-1:0];
                ovf     <= ovf | sum[OUT_W];
            end
        end
    end

endmodule
